// File: rtl/voted_store_buffer.sv
// rtl/voted_store_buffer.sv - speculative store buffer between voter and data memory; forwarding built when VOTED_STORE_BUF_FWD_EN is defined
module voted_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_in,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    output logic                       st_ready,
    input  logic                       commit,
    input  logic                       flush,
    output logic                       mem_we,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_hit,
    output logic [DW-1:0]              ld_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow_err
);

    // Pointer width carries one extra wrap bit so full and empty are distinguishable.
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = PW - 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    logic [AW-1:0] ent_addr [DEPTH];
    logic [DW-1:0] ent_data [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] cptr;
    logic [PW-1:0] tail;

    logic [PW-1:0] pending_cnt;
    logic [PW-1:0] committed_cnt;
    logic [PW-1:0] cptr_next;
    logic          full;
    logic          do_enq;
    logic          do_drain;

    // Occupancy and the control decisions for this cycle, all from registered pointers.
    always_comb begin
        count         = tail - head;
        pending_cnt   = tail - cptr;
        committed_cnt = cptr - head;
        full          = (count == FULL_CNT);
        st_ready      = !full;
        do_enq        = st_valid && !full && !flush;
        do_drain      = (committed_cnt != '0);
        cptr_next     = (commit && (pending_cnt != '0)) ? cptr + PW'(1) : cptr;
    end

    // Entry storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_enq && !rst_in) begin
            ent_addr[tail[IW-1:0]] <= st_addr;
            ent_data[tail[IW-1:0]] <= st_data;
        end
    end

    // Pointer updates, drain to memory and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            head         <= '0;
            cptr         <= '0;
            tail         <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            overflow_err <= 1'b0;
        end else begin
            cptr <= cptr_next;
            // Flush rolls tail back to the (possibly just advanced) commit boundary.
            if (flush) begin
                tail <= cptr_next;
            end else if (do_enq) begin
                tail <= tail + PW'(1);
            end
            if (st_valid && full && !flush) begin
                overflow_err <= 1'b1;
            end
            if (do_drain) begin
                mem_we    <= 1'b1;
                mem_addr  <= ent_addr[head[IW-1:0]];
                mem_wdata <= ent_data[head[IW-1:0]];
                head      <= head + PW'(1);
            end else begin
                mem_we <= 1'b0;
            end
        end
    end

`ifdef VOTED_STORE_BUF_FWD_EN
    // Walk occupied entries oldest to youngest so the youngest word match overrides.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PW'(i) < count) &&
                (ent_addr[head[IW-1:0] + IW'(i)][AW-1:2] == ld_addr[AW-1:2])) begin
                ld_hit  = 1'b1;
                ld_data = ent_data[head[IW-1:0] + IW'(i)];
            end
        end
    end
`else
    logic unused_ld_addr;

    // Without forwarding the load path reads memory only.
    always_comb begin
        ld_hit         = 1'b0;
        ld_data        = '0;
        unused_ld_addr = ^ld_addr;
    end
`endif

endmodule

// File: tb/tb_voted_store_buffer.sv
// tb/tb_voted_store_buffer.sv - scoreboard bench for voted_store_buffer
module tb_voted_store_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_ready;
    logic        commit = 1'b0;
    logic        flush = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] ld_addr = '0;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic [2:0]  count;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    ent_t cq[$];
    ent_t pq[$];
    ent_t exp_q[$];
    bit   ov = 1'b0;

    voted_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_in(rst_in),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .commit(commit), .flush(flush),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .count(count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Memory-side monitor: every write the DUT presents must be the next expected one.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    check("mem_addr", mem_addr, e.a);
                    check("mem_wdata", mem_wdata, e.d);
                end
            end else if (exp_q.size() != 0) begin
                check("missing_write", {31'd0, mem_we}, 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    // One cycle: check status against the model, drive inputs, then advance the model.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic c, input logic f, input logic r, input logic [31:0] la);
        int   total;
        int   pend;
        logic exp_hit;
        logic [31:0] exp_ld;
        @(negedge clk);
        ld_addr = la;
        #1;
        total = cq.size() + pq.size();
        exp_hit = 1'b0;
        exp_ld  = '0;
`ifdef VOTED_STORE_BUF_FWD_EN
        foreach (cq[i]) if (cq[i].a[31:2] == la[31:2]) begin exp_hit = 1'b1; exp_ld = cq[i].d; end
        foreach (pq[i]) if (pq[i].a[31:2] == la[31:2]) begin exp_hit = 1'b1; exp_ld = pq[i].d; end
`endif
        check("count", {29'd0, count}, total);
        check("st_ready", {31'd0, st_ready}, {31'd0, total != DEPTH});
        check("overflow_err", {31'd0, overflow_err}, {31'd0, ov});
        check("ld_hit", {31'd0, ld_hit}, {31'd0, exp_hit});
        check("ld_data", ld_data, exp_ld);
        st_valid = v; st_addr = a; st_data = d;
        commit = c; flush = f; rst_in = r;
        @(posedge clk);
        if (r) begin
            cq.delete();
            pq.delete();
            ov = 1'b0;
        end else begin
            pend = pq.size();
            if (cq.size() > 0) exp_q.push_back(cq.pop_front());
            if (c && pend > 0) cq.push_back(pq.pop_front());
            if (v && !f) begin
                if (total == DEPTH) ov = 1'b1;
                else pq.push_back('{a: a, d: d});
            end
            if (f) pq.delete();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'h0000_0010);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_in = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Store then commit two cycles later.
        step(1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(3);

        // Rollback keeps only the committed store.
        step(1, 32'h20, 32'h11, 0, 0, 0, 0);
        step(1, 32'h24, 32'h22, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(3);

        // Fill, overflow, then drain in order.
        for (int i = 0; i < 4; i++) step(1, 32'h100 + 4 * i, 32'hA0 + i, 0, 0, 0, 0);
        step(1, 32'h40, 32'h55, 0, 0, 0, 32'h40);
        idle(1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 32'h104);
        idle(3);

        // Forwarding: youngest same-word store wins, gone after flush.
        step(1, 32'h30, 32'hA, 0, 0, 0, 0);
        step(1, 32'h30, 32'hB, 0, 0, 0, 32'h32);
        step(0, 0, 0, 0, 0, 0, 32'h32);
        step(0, 0, 0, 0, 1, 0, 32'h32);
        step(0, 0, 0, 0, 0, 0, 32'h32);

        // Commit and flush together; store and flush together.
        step(1, 32'h50, 32'h1, 0, 0, 0, 0);
        step(1, 32'h54, 32'h2, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(1, 32'h58, 32'h3, 0, 1, 0, 0);
        idle(3);

        // Reset while a write is on the memory port.
        step(1, 32'h60, 32'h4, 0, 0, 0, 0);
        step(1, 32'h64, 32'h5, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(2);

        // Randomized traffic in two mixes: store-heavy and commit-heavy.
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 400; n++) begin
                logic v, c, f, r;
                logic [31:0] a, la;
                v  = ($urandom_range(0, 99) < (ph == 0 ? 70 : 40));
                c  = ($urandom_range(0, 99) < (ph == 0 ? 30 : 60));
                f  = ($urandom_range(0, 99) < (ph == 0 ? 5 : 10));
                r  = ($urandom_range(0, 199) == 0);
                a  = 32'h10 * $urandom_range(1, 4) + $urandom_range(0, 7);
                la = 32'h10 * $urandom_range(1, 4) + $urandom_range(0, 7);
                step(v, a, $urandom, c, f, r, la);
            end
        end

        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0, 0, 0);
        idle(DEPTH + 3);
        check("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
